// File: rtl/tone_generator.sv
// tone_generator: programmable 50 % duty square wave from a whole-Hz frequency word
module tone_generator #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int HZ_WIDTH  = 10,
    parameter int CNT_WIDTH = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HZ_WIDTH-1:0] Hz,
    input  logic                load,
    input  logic                Enable,
    output logic                JB1,
    output logic                busy,
    output logic [HZ_WIDTH-1:0] ActiveHz
);
    localparam int SW = $clog2(CNT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] DIVIDEND = CNT_WIDTH'(CLK_HZ / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic [CNT_WIDTH:0]   rem;
    logic [CNT_WIDTH+1:0] trial, divisor;
    logic [CNT_WIDTH-1:0] quo, quo_next, hp, counter;
    logic [HZ_WIDTH-1:0]  pend_hz;
    logic [SW-1:0]        steps;
    logic                 pend_valid, fits, start, stop, done, wrap, commit_idle, commit_run;

    // divider step, request decode, phase wrap detection and tone next-state
    always_comb begin
        trial       = {rem, quo[CNT_WIDTH-1]};
        divisor     = (CNT_WIDTH+2)'(pend_hz);
        fits        = trial >= divisor;
        quo_next    = {quo[CNT_WIDTH-2:0], fits};
        start       = load && !busy && Hz != '0;
        stop        = load && !busy && Hz == '0;
        done        = busy && steps == SW'(CNT_WIDTH - 1);
        wrap        = state == RUN && Enable && counter == hp - CNT_WIDTH'(1);
        commit_idle = done && state == IDLE;
        commit_run  = pend_valid && state == RUN && (wrap || !Enable);
        state_next  = stop ? IDLE : commit_idle ? RUN : state;
    end

    // tone state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // restoring divider: quotient shifts in MSB first while the dividend shifts out of quo
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            steps   <= '0;
            rem     <= '0;
            quo     <= '0;
            pend_hz <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            steps   <= '0;
            rem     <= '0;
            quo     <= DIVIDEND;
            pend_hz <= Hz;
        end else if (busy) begin
            rem   <= fits ? (CNT_WIDTH+1)'(trial - divisor) : (CNT_WIDTH+1)'(trial);
            quo   <= quo_next;
            steps <= steps + SW'(1);
            busy  <= !done;
        end
    end

    // half-period counter and output; a finished quotient is adopted only at a phase boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= '0;
            JB1        <= 1'b0;
            hp         <= '0;
            ActiveHz   <= '0;
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= start ? 1'b0 : (done && state == RUN) ? 1'b1 : (stop || commit_run) ? 1'b0 : pend_valid;
            if (stop) begin
                counter  <= '0;
                JB1      <= 1'b0;
                hp       <= '0;
                ActiveHz <= '0;
            end else if (commit_idle) begin
                counter  <= '0;
                JB1      <= 1'b0;
                hp       <= quo_next;
                ActiveHz <= pend_hz;
            end else if (state == RUN) begin
                counter <= (wrap || !Enable) ? '0 : counter + CNT_WIDTH'(1);
                JB1     <= Enable && (JB1 ^ wrap);
                if (commit_run) begin
                    hp       <= quo;
                    ActiveHz <= pend_hz;
                end
            end
        end
    end
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: cycle model of the tone rules plus directed phase-length checks
module tb_tone_generator;
    localparam int CLK_HZ    = 60_000;
    localparam int HZ_WIDTH  = 10;
    localparam int CNT_WIDTH = 26;

    logic                clk = 1'b0, rst = 1'b1, load = 1'b0, Enable = 1'b0;
    logic [HZ_WIDTH-1:0] Hz = '0;
    logic                JB1, busy;
    logic [HZ_WIDTH-1:0] ActiveHz;

    int compares = 0, fails = 0, toggles = 0;

    tone_generator #(.CLK_HZ(CLK_HZ), .HZ_WIDTH(HZ_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst), .Hz(Hz), .load(load), .Enable(Enable),
        .JB1(JB1), .busy(busy), .ActiveHz(ActiveHz)
    );

    always #5 clk = ~clk;

    function automatic int model_hp(input int h);
        return CLK_HZ / (2 * h);
    endfunction

    // model: remaining busy cycles, remaining cycles of the current phase, pending result
    int   m_busy_left = 0, m_left = 0, m_hp = 0, m_pend_hz = 0, m_active = 0;
    logic m_run = 1'b0, m_pend = 1'b0, m_jb1 = 1'b0;

    task automatic m_apply();
        m_hp     = model_hp(m_pend_hz);
        m_active = m_pend_hz;
        m_pend   = 1'b0;
    endtask

    // advance the model by one clock using the inputs sampled at this edge
    always @(posedge clk) begin : model
        logic b;
        if (rst) begin
            m_busy_left = 0; m_left = 0; m_hp = 0; m_pend_hz = 0; m_active = 0;
            m_run = 1'b0; m_pend = 1'b0; m_jb1 = 1'b0;
        end else begin
            b = m_busy_left > 0;
            if (load && !b && Hz == 0) begin
                m_run = 1'b0; m_jb1 = 1'b0; m_active = 0; m_pend = 1'b0;
            end else begin
                if (m_run) begin
                    if (!Enable) begin
                        m_jb1 = 1'b0;
                        if (m_pend) m_apply();
                        m_left = m_hp;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_jb1 = !m_jb1;
                            if (m_pend) m_apply();
                            m_left = m_hp;
                        end
                    end
                end
                if (m_busy_left == 1) begin
                    if (!m_run) begin
                        m_run = 1'b1; m_jb1 = 1'b0;
                        m_apply();
                        m_left = m_hp;
                    end else m_pend = 1'b1;
                end
                if (b) m_busy_left--;
                if (load && !b) begin
                    m_pend_hz = int'(Hz); m_busy_left = CNT_WIDTH; m_pend = 1'b0;
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        compares++;
        if (JB1 !== m_jb1 || busy !== (m_busy_left > 0) || ActiveHz !== HZ_WIDTH'(m_active)) begin
            fails++;
            $display("FAIL model t=%0t JB1/busy/ActiveHz got %b/%b/%0d expected %b/%b/%0d",
                     $time, JB1, busy, ActiveHz, m_jb1, m_busy_left > 0, m_active);
        end
    end

    // toggle counter, updated away from both edges the initial block uses
    logic prev_jb1 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (JB1 !== prev_jb1) toggles++;
        prev_jb1 = JB1;
    end

    task automatic check(input string name, input int act, input int exp);
        compares++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_load(input int h);
        Hz   = HZ_WIDTH'(h);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_edge(input int limit, output int n);
        logic p;
        p = JB1;
        n = 0;
        while (JB1 === p && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n, t0;

    initial begin
        rst = 1'b1; load = 1'b1; Hz = 10'd500;
        repeat (3) @(negedge clk);
        check("reset_jb1", JB1, 0);
        check("reset_busy", busy, 0);
        check("reset_active", ActiveHz, 0);
        rst = 1'b0; load = 1'b0; Hz = '0;
        repeat (2000) @(negedge clk);
        check("idle_no_toggle", toggles, 0);

        Enable = 1'b1;
        pulse_load(1000);
        wait_busy(n);
        check("busy_len_1000", n, 26);
        check("active_1000", ActiveHz, 1000);
        wait_edge(100, n);
        check("first_rise_1000", n, 30);
        check("first_rise_level", JB1, 1);
        for (int i = 0; i < 8; i++) begin
            wait_edge(100, n);
            check("phase_1000", n, 30);
        end

        pulse_load(500);
        repeat (4) @(negedge clk);
        pulse_load(7);
        check("busy_during_ignored_load", busy, 1);
        wait_edge(100, n);
        check("retune_old_phase_rest", n, 24);
        check("active_500_at_wrap", ActiveHz, 500);
        for (int i = 0; i < 2; i++) begin
            wait_edge(200, n);
            check("phase_500", n, 60);
        end

        repeat (33) @(negedge clk);
        pulse_load(1000);
        wait_edge(200, n);
        check("simul_phase_rest", n, 26);
        check("simul_active_kept", ActiveHz, 500);
        wait_edge(200, n);
        check("simul_old_hp_phase", n, 60);
        check("simul_active_1000", ActiveHz, 1000);
        wait_edge(200, n);
        check("simul_new_hp_phase", n, 30);

        repeat (10) @(negedge clk);
        Enable = 1'b0;
        @(negedge clk);
        t0 = toggles;
        check("enable_low_jb1", JB1, 0);
        repeat (100) @(negedge clk);
        check("enable_low_hold", toggles - t0, 0);
        Enable = 1'b1;
        wait_edge(200, n);
        check("reenable_first_rise", n, 30);
        check("reenable_level", JB1, 1);

        repeat (7) @(negedge clk);
        pulse_load(0);
        check("stop_jb1", JB1, 0);
        check("stop_active", ActiveHz, 0);
        t0 = toggles;
        repeat (200) @(negedge clk);
        check("stop_no_toggle", toggles - t0, 0);

        pulse_load(1023);
        wait_busy(n);
        check("busy_len_1023", n, 26);
        check("active_1023", ActiveHz, 1023);
        wait_edge(100, n);
        check("first_rise_1023", n, 29);
        wait_edge(100, n);
        check("phase_1023", n, 29);

        pulse_load(7);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_active", ActiveHz, 0);
        check("rst_mid_jb1", JB1, 0);
        t0 = toggles;
        repeat (5000) @(negedge clk);
        check("rst_no_commit_toggles", toggles - t0, 0);
        check("rst_no_commit_active", ActiveHz, 0);

        pulse_load(1);
        wait_busy(n);
        check("active_1", ActiveHz, 1);
        wait_edge(40000, n);
        check("first_rise_1", n, 30000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
